// File: rtl/prog_loader.sv
// Boot loader: takes a byte stream (16-bit word count, then big-endian words) and writes it to memory, then releases core_rst.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int N = 5,
  parameter int M = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         load_we,
  output logic [N-1:0] load_addr,
  output logic [M-1:0] load_data,
  output logic         core_rst,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [16:0] CAP = 17'(2**N);

  state_t         r_state;
  state_t         w_next;
  logic [15:0]    r_cnt;
  logic [1:0]     r_bcnt;
  logic [N-1:0]   r_idx;
  logic [M-9:0]   r_word;
  logic [N-1:0]   r_load_addr;
  logic [M-1:0]   r_load_data;
  logic           r_core_rst;
  logic           w_xfer;
  logic [15:0]    w_cnt_full;
  logic [M-1:0]   w_shift;
  logic           w_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]     r_csum;
`endif

  assign in_ready = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                    || (r_state == S_CHK)
`endif
                    ;
  assign w_xfer     = in_valid && in_ready;
  assign w_cnt_full = {r_cnt[15:8], in_byte};
  assign w_shift    = {r_word, in_byte};
  assign w_last     = (({{(17-N){1'b0}}, r_idx} + 17'd1) == {1'b0, r_cnt});

  assign load_addr = r_load_addr;
  assign load_data = r_load_data;
  assign core_rst  = r_core_rst;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_HDR_HI;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    load_we = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_xfer) begin
          if (w_cnt_full == 16'd0)              w_next = S_FINAL;
          else if ({1'b0, w_cnt_full} > CAP)    w_next = S_ERR;
          else                                  w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
      S_WRITE: begin
        load_we = 1'b1;
        w_next  = w_last ? S_FINAL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (w_xfer) w_next = (in_byte == r_csum) ? S_DONE : S_ERR;
`endif
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: w_next = S_ERR;
    endcase
  end

  // load_addr/load_data are captured as the word completes so they hold after the write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt       <= '0;
      r_bcnt      <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_load_addr <= '0;
      r_load_data <= '0;
      r_core_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_core_rst <= (w_next != S_DONE);
      if (r_state == S_WRITE) r_idx <= r_idx + 1'b1;
      if (w_xfer) begin
        case (r_state)
          S_HDR_HI: r_cnt[15:8] <= in_byte;
          S_HDR_LO: r_cnt[7:0]  <= in_byte;
          S_DATA: begin
            r_word <= w_shift[M-9:0];
            r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ in_byte;
`endif
            if (r_bcnt == 2'd3) begin
              r_load_addr <= r_idx;
              r_load_data <= w_shift;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
